// File: rtl/wb_arbiter_2.sv
// Two-master round-robin Wishbone arbiter; 1-cycle grant latency, data path unregistered, grant held while CYC high.
// Optional stall timeout under WB_ARB_TIMEOUT_EN; otherwise a stalled slave holds the bus.
module wb_arbiter_2 #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t     state_q;
  logic       last_q;
  logic [1:0] grant_q;
  logic       sel0, sel1;
  logic       stb_raw, cyc_raw;
  logic       to_hit;

  assign sel0    = grant_q[0];
  assign sel1    = grant_q[1];
  assign grant_o = grant_q;

  assign stb_raw = (sel0 & m0_stb_i) | (sel1 & m1_stb_i);
  assign cyc_raw = (sel0 & m0_cyc_i) | (sel1 & m1_cyc_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;
  logic          stall;

  // Stall is judged on the ungated strobe so the abort itself cannot feed back.
  assign stall  = stb_raw & ~wbs_ack_i & ~wbs_err_i;
  assign to_hit = stall && (to_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!stall || to_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= G0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= G1;
            grant_q <= 2'b10;
          end
        end
        G0: begin
          if (!m0_cyc_i || to_hit) begin
            last_q <= 1'b0;
            if (m1_cyc_i) begin
              state_q <= G1;
              grant_q <= 2'b10;
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        G1: begin
          if (!m1_cyc_i || to_hit) begin
            last_q <= 1'b1;
            if (m0_cyc_i) begin
              state_q <= G0;
              grant_q <= 2'b01;
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Request mux: everything is zero while idle.
  assign wbs_adr_o = sel0 ? m0_adr_i : (sel1 ? m1_adr_i : '0);
  assign wbs_dat_o = sel0 ? m0_dat_i : (sel1 ? m1_dat_i : '0);
  assign wbs_sel_o = sel0 ? m0_sel_i : (sel1 ? m1_sel_i : '0);
  assign wbs_we_o  = (sel0 & m0_we_i) | (sel1 & m1_we_i);
  assign wbs_stb_o = stb_raw & ~to_hit;
  assign wbs_cyc_o = cyc_raw & ~to_hit;

  assign m0_dat_o = wbs_dat_i;
  assign m1_dat_o = wbs_dat_i;
  assign m0_ack_o = sel0 & wbs_ack_i;
  assign m1_ack_o = sel1 & wbs_ack_i;
  assign m0_err_o = sel0 & (wbs_err_i | to_hit);
  assign m1_err_o = sel1 & (wbs_err_i | to_hit);

endmodule
